// File: rtl/sram_arb_pkg.sv
// Shared definitions for the external SRAM arbiter.
//   state_t      : access-cycle states of the arbiter FSM
//   PORT_CPU/HOST: requester indices used for grant and last-grant tracking
//   DEF_*        : default geometry of the board SRAM and access timing
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;

    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : raw requests, [0] = CPU, [1] = HOST
//   lock       : masks the CPU request (HOST exclusive)
//   update     : commit the current grant as the last grant
//   gnt_valid  : some eligible request exists
//   gnt_port   : port index that wins this cycle
module sram_rr_arb
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       update,
    output logic       gnt_valid,
    output logic       gnt_port
);

    logic       last_gnt_reg;
    logic [1:0] eligible;

    assign eligible  = {req[PORT_HOST], req[PORT_CPU] & ~lock};
    assign gnt_valid = |eligible;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        gnt_port = last_gnt_reg;
        if (eligible == 2'b11) begin
            gnt_port = ~last_gnt_reg;
        end else if (eligible[PORT_HOST]) begin
            gnt_port = 1'(PORT_HOST);
        end else if (eligible[PORT_CPU]) begin
            gnt_port = 1'(PORT_CPU);
        end
    end

    // Starting from HOST means the CPU wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= 1'(PORT_HOST);
        end else if (update && gnt_valid) begin
            last_gnt_reg <= gnt_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU data port (port 0) and the
// host loader (port 1). Each access runs IDLE -> SETUP -> ACCESS(xWAIT) ->
// DONE with registered active-low strobes; DONE pulses the winner's ack.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cpu_* / host_*             : req/we/be/addr/wdata in, ack/rdata out
//   lock_host                  : CPU never granted while high
//   busy                       : FSM not in IDLE
//   sram_addr, sram_dq         : SRAM address and bidirectional data
//   sram_ce_n/oe_n/we_n/ub_n/lb_n : SRAM strobes
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [1:0]        host_be,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              lock_host,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              port_reg, port_next;
    logic              we_reg, we_next;
    logic [1:0]        be_reg, be_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
    logic              ce_n_reg, ce_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic              ub_n_reg, ub_n_next;
    logic              lb_n_reg, lb_n_next;
    logic              dq_oe_reg, dq_oe_next;
    logic              cpu_ack_reg, cpu_ack_next;
    logic              host_ack_reg, host_ack_next;
    logic [DATA_W-1:0] cpu_rdata_reg, host_rdata_reg;

    logic              gnt_valid, gnt_port;
    logic              capture;

    sram_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({host_req, cpu_req}),
        .lock      (lock_host),
        .update    (state_reg == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Read data is sampled at the end of the last ACCESS cycle so it is
    // already stable in the DONE (ack) cycle.
    assign capture = (state_reg == ACCESS) && (cnt_reg == 4'd0) && !we_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        port_next  = port_reg;
        we_next    = we_reg;
        be_next    = be_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        unique case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    state_next = SETUP;
                    port_next  = gnt_port;
                    we_next    = gnt_port ? host_we    : cpu_we;
                    be_next    = gnt_port ? host_be    : cpu_be;
                    addr_next  = gnt_port ? host_addr  : cpu_addr;
                    wdata_next = gnt_port ? host_wdata : cpu_wdata;
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_next   = 4'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pin values are derived from the state being entered so that every
    // strobe is a flop output aligned with its state. The address only
    // changes on entry to SETUP, a full cycle before we_n can fall.
    always_comb begin
        sram_addr_next = sram_addr_reg;
        ce_n_next      = 1'b1;
        oe_n_next      = 1'b1;
        we_n_next      = 1'b1;
        ub_n_next      = 1'b1;
        lb_n_next      = 1'b1;
        dq_oe_next     = 1'b0;
        cpu_ack_next   = 1'b0;
        host_ack_next  = 1'b0;
        unique case (state_next)
            SETUP: begin
                sram_addr_next = addr_next;
                ce_n_next      = 1'b0;
                ub_n_next      = ~be_next[1];
                lb_n_next      = ~be_next[0];
                oe_n_next      = we_next;
                dq_oe_next     = we_next;
            end
            ACCESS: begin
                ce_n_next  = 1'b0;
                ub_n_next  = ~be_next[1];
                lb_n_next  = ~be_next[0];
                oe_n_next  = we_next;
                we_n_next  = ~we_next;
                dq_oe_next = we_next;
            end
            DONE: begin
                ce_n_next     = 1'b0;
                ub_n_next     = ~be_next[1];
                lb_n_next     = ~be_next[0];
                dq_oe_next    = we_next;
                cpu_ack_next  = (port_next == 1'(PORT_CPU));
                host_ack_next = (port_next == 1'(PORT_HOST));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            port_reg       <= 1'(PORT_CPU);
            we_reg         <= 1'b0;
            be_reg         <= 2'b00;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            sram_addr_reg  <= '0;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            ub_n_reg       <= 1'b1;
            lb_n_reg       <= 1'b1;
            dq_oe_reg      <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            host_ack_reg   <= 1'b0;
            cpu_rdata_reg  <= '0;
            host_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            port_reg      <= port_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            sram_addr_reg <= sram_addr_next;
            ce_n_reg      <= ce_n_next;
            oe_n_reg      <= oe_n_next;
            we_n_reg      <= we_n_next;
            ub_n_reg      <= ub_n_next;
            lb_n_reg      <= lb_n_next;
            dq_oe_reg     <= dq_oe_next;
            cpu_ack_reg   <= cpu_ack_next;
            host_ack_reg  <= host_ack_next;
            if (capture) begin
                if (port_reg == 1'(PORT_CPU)) begin
                    cpu_rdata_reg <= sram_dq;
                end else begin
                    host_rdata_reg <= sram_dq;
                end
            end
        end
    end

    assign sram_dq    = dq_oe_reg ? wdata_reg : {DATA_W{1'bz}};
    assign sram_addr  = sram_addr_reg;
    assign sram_ce_n  = ce_n_reg;
    assign sram_oe_n  = oe_n_reg;
    assign sram_we_n  = we_n_reg;
    assign sram_ub_n  = ub_n_reg;
    assign sram_lb_n  = lb_n_reg;
    assign cpu_ack    = cpu_ack_reg;
    assign host_ack   = host_ack_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign host_rdata = host_rdata_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance 0 runs with WAIT_CYCLES = 1, instance 1
// with WAIT_CYCLES = 3. Each instance drives a behavioural async SRAM.
// A transaction-level reference (grant order, ack cycle, memory contents)
// predicts every ack, rdata value and write-strobe window.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Inputs, indexed [instance][port]
    logic        req_v   [2][2];
    logic        we_v    [2][2];
    logic [1:0]  be_v    [2][2];
    logic [19:0] addr_v  [2][2];
    logic [15:0] wdata_v [2][2];
    logic        lock_v  [2];

    // Outputs
    wire         ack_v   [2][2];
    wire  [15:0] rdata_v [2][2];
    wire         busy_v  [2];
    wire         ce_n_v  [2];
    wire         oe_n_v  [2];
    wire         we_n_v  [2];
    wire         ub_n_v  [2];
    wire         lb_n_v  [2];
    wire  [19:0] saddr_v [2];

    int vectors     = 0;
    int miscompares = 0;

    int          remain    [2][2];
    int          last_gnt  [2];
    logic [15:0] exp_rdata [2][2];
    logic [15:0] ref_mem   [int];

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic int wait_of(input int k);
        return 1 + 2 * k;
    endfunction

    function automatic logic [15:0] ref_read(input int k, input logic [19:0] a);
        int key;
        key = k * 1048576 + int'(a);
        if (ref_mem.exists(key)) return ref_mem[key];
        return init_val(a);
    endfunction

    task automatic ref_write(input int k, input logic [19:0] a, input logic [1:0] be,
                             input logic [15:0] d);
        logic [15:0] cur;
        cur = ref_read(k, a);
        if (be[1]) cur[15:8] = d[15:8];
        if (be[0]) cur[7:0]  = d[7:0];
        ref_mem[k * 1048576 + int'(a)] = cur;
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int W = 1 + 2 * gi;
            wire  [15:0] sram_dq;
            logic [15:0] rd_val;
            logic [15:0] mem [logic [19:0]];

            sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20), .DATA_W(16)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .cpu_req    (req_v[gi][0]),
                .cpu_we     (we_v[gi][0]),
                .cpu_be     (be_v[gi][0]),
                .cpu_addr   (addr_v[gi][0]),
                .cpu_wdata  (wdata_v[gi][0]),
                .cpu_ack    (ack_v[gi][0]),
                .cpu_rdata  (rdata_v[gi][0]),
                .host_req   (req_v[gi][1]),
                .host_we    (we_v[gi][1]),
                .host_be    (be_v[gi][1]),
                .host_addr  (addr_v[gi][1]),
                .host_wdata (wdata_v[gi][1]),
                .host_ack   (ack_v[gi][1]),
                .host_rdata (rdata_v[gi][1]),
                .lock_host  (lock_v[gi]),
                .busy       (busy_v[gi]),
                .sram_addr  (saddr_v[gi]),
                .sram_dq    (sram_dq),
                .sram_ce_n  (ce_n_v[gi]),
                .sram_oe_n  (oe_n_v[gi]),
                .sram_we_n  (we_n_v[gi]),
                .sram_ub_n  (ub_n_v[gi]),
                .sram_lb_n  (lb_n_v[gi])
            );

            // Asynchronous SRAM: drives dq while selected and output-enabled.
            assign sram_dq = (!ce_n_v[gi] && !oe_n_v[gi] && we_n_v[gi]) ? rd_val : 16'hzzzz;

            always @(negedge clk) begin
                logic [15:0] cur;
                if (!ce_n_v[gi] && !we_n_v[gi]) begin
                    cur = mem.exists(saddr_v[gi]) ? mem[saddr_v[gi]] : init_val(saddr_v[gi]);
                    if (!ub_n_v[gi]) cur[15:8] = sram_dq[15:8];
                    if (!lb_n_v[gi]) cur[7:0]  = sram_dq[7:0];
                    mem[saddr_v[gi]] = cur;
                end
                rd_val = mem.exists(saddr_v[gi]) ? mem[saddr_v[gi]] : init_val(saddr_v[gi]);
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int k, input int p, input logic we, input logic [1:0] be,
                              input logic [19:0] a, input logic [15:0] d);
        we_v[k][p]    = we;
        be_v[k][p]    = be;
        addr_v[k][p]  = a;
        wdata_v[k][p] = d;
        req_v[k][p]   = 1'b1;
    endtask

    task automatic new_fields(input int k, input int p);
        logic we;
        we = 1'($urandom_range(0, 1));
        set_fields(k, p, we, we ? 2'($urandom_range(0, 3)) : 2'b11,
                   20'h12340 + 20'($urandom_range(0, 7)), 16'($urandom));
    endtask

    // Runs instance k until no eligible requester remains. The model picks
    // the winner from pending counts, lock and last grant; an ack is due
    // 2+WAIT cycles after the IDLE cycle in which the grant is made.
    task automatic run(input int k);
        int cyc, due, gp, idle_at, we_cnt;
        bit inflight, e0, e1, exp_ack;
        logic [1:0] nb;
        cyc = 0; due = 0; gp = 0; idle_at = 0; we_cnt = 0; inflight = 0;
        while (1) begin
            if (!inflight && cyc >= idle_at) begin
                e0 = (remain[k][0] > 0) && !lock_v[k];
                e1 = (remain[k][1] > 0);
                if (!e0 && !e1) break;
                if (e0 && e1) gp = 1 - last_gnt[k];
                else          gp = e1 ? 1 : 0;
                last_gnt[k] = gp;
                inflight    = 1;
                due         = cyc + 2 + wait_of(k);
                we_cnt      = 0;
            end
            if (cyc > 400) begin
                vectors++;
                miscompares++;
                $error("FAIL timeout inst%0d observed no completion expected all acks", k);
                break;
            end
            tick();
            cyc++;
            if (inflight && !we_n_v[k]) begin
                nb = ~be_v[k][gp];
                chk("we_bytes", {ub_n_v[k], lb_n_v[k]}, nb);
                chk("we_addr", saddr_v[k], addr_v[k][gp]);
                chk("we_oe_n", oe_n_v[k], 1'b1);
                we_cnt++;
            end
            chk("busy", busy_v[k], inflight && cyc <= due);
            for (int p = 0; p < 2; p++) begin
                exp_ack = inflight && (cyc == due) && (p == gp);
                chk($sformatf("ack_i%0d_p%0d", k, p), ack_v[k][p], exp_ack);
            end
            if (inflight && cyc == due) begin
                if (we_v[k][gp]) begin
                    ref_write(k, addr_v[k][gp], be_v[k][gp], wdata_v[k][gp]);
                end else begin
                    exp_rdata[k][gp] = ref_read(k, addr_v[k][gp]);
                end
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("rdata_i%0d_p%0d", k, p), rdata_v[k][p], exp_rdata[k][p]);
                end
                chk("we_low_cycles", we_cnt, we_v[k][gp] ? wait_of(k) : 0);
                $display("inst%0d %s %s addr=%05h be=%b data=%04h ack_cycle=%0d",
                         k, gp ? "HOST" : "CPU ", we_v[k][gp] ? "WR" : "RD", addr_v[k][gp],
                         be_v[k][gp], we_v[k][gp] ? wdata_v[k][gp] : rdata_v[k][gp], cyc);
                remain[k][gp]--;
                if (remain[k][gp] > 0) new_fields(k, gp);
                else                   req_v[k][gp] = 1'b0;
                inflight = 0;
                idle_at  = cyc + 1;
            end
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            last_gnt[k] = 1;
            for (int p = 0; p < 2; p++) begin
                exp_rdata[k][p] = 16'h0000;
                remain[k][p]    = 0;
            end
        end
    endtask

    task automatic check_idle_pins(input int k, input string tag);
        chk({tag, "_ce_n"}, ce_n_v[k], 1'b1);
        chk({tag, "_oe_n"}, oe_n_v[k], 1'b1);
        chk({tag, "_we_n"}, we_n_v[k], 1'b1);
        chk({tag, "_ub_n"}, ub_n_v[k], 1'b1);
        chk({tag, "_lb_n"}, lb_n_v[k], 1'b1);
        chk({tag, "_busy"}, busy_v[k], 1'b0);
        chk({tag, "_cpu_ack"}, ack_v[k][0], 1'b0);
        chk({tag, "_host_ack"}, ack_v[k][1], 1'b0);
        chk({tag, "_cpu_rdata"}, rdata_v[k][0], 16'h0000);
        chk({tag, "_host_rdata"}, rdata_v[k][1], 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lock_v[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req_v[k][p] = 1'b0; we_v[k][p] = 1'b0; be_v[k][p] = 2'b00;
                addr_v[k][p] = '0; wdata_v[k][p] = '0;
            end
        end
        reset_model();
        tick(); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            check_idle_pins(k, "reset");
            chk("reset_addr", saddr_v[k], 20'h0);
        end
        rst_n = 1'b1;
        tick();

        // HOST write then read back, WAIT = 1
        set_fields(0, 1, 1'b1, 2'b11, 20'h12345, 16'hBEEF);
        remain[0][1] = 1;
        run(0);
        set_fields(0, 1, 1'b0, 2'b11, 20'h12345, 16'h0000);
        remain[0][1] = 1;
        run(0);
        chk("host_read_beef", rdata_v[0][1], 16'hBEEF);

        // Simultaneous requests alternate, CPU first
        new_fields(0, 0); new_fields(0, 1);
        remain[0][0] = 4; remain[0][1] = 4;
        run(0);

        // Lock: only HOST served, then CPU right after unlock
        lock_v[0] = 1'b1;
        new_fields(0, 0); new_fields(0, 1);
        remain[0][0] = 1; remain[0][1] = 4;
        run(0);
        chk("lock_cpu_pending", remain[0][0], 1);
        lock_v[0] = 1'b0;
        run(0);

        // Upper-byte write keeps the lower byte
        set_fields(0, 0, 1'b1, 2'b11, 20'h00777, 16'h1234);
        remain[0][0] = 1;
        run(0);
        set_fields(0, 0, 1'b1, 2'b10, 20'h00777, 16'hAB00);
        remain[0][0] = 1;
        run(0);
        set_fields(0, 0, 1'b0, 2'b11, 20'h00777, 16'h0000);
        remain[0][0] = 1;
        run(0);
        chk("upper_byte_merge", rdata_v[0][0], 16'hAB34);

        // Random mixed traffic
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 2; p++) begin
                remain[0][p] = $urandom_range(0, 3);
                if (remain[0][p] > 0) new_fields(0, p);
            end
            run(0);
        end

        // Reset in the ACCESS phase of a write aborts it
        set_fields(0, 0, 1'b1, 2'b11, 20'hFFFFF, 16'h5555);
        tick();
        tick();
        chk("abort_in_access", we_n_v[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_pins(0, "abort");
        req_v[0][0] = 1'b0;
        reset_model();
        tick();
        check_idle_pins(0, "abort_hold");
        rst_n = 1'b1;
        tick();
        set_fields(0, 0, 1'b0, 2'b11, 20'h12345, 16'h0000);
        remain[0][0] = 1;
        run(0);

        // WAIT = 3: held CPU read request gives two back-to-back accesses
        set_fields(1, 0, 1'b0, 2'b11, 20'h00042, 16'h0000);
        remain[1][0] = 2;
        run(1);
        new_fields(1, 0); new_fields(1, 1);
        remain[1][0] = 3; remain[1][1] = 3;
        run(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
